aes_128_key_feeder: RTL and testbench

- Responder on the round-key side of the AES-128 core: holds the 11 expanded round keys and supplies `key_round` in step with the core's `key_ready` requests.
- Keys are loaded by software or a key-expansion master through a simple write port.
- Keys are delivered in ascending order for encryption or descending order for the decryption datapath.
- Sits beside the core/control pair and observes the same `in_en` and `out_en`.

---
 rtl/aes_128_key_feeder_if.sv | 36 +++
 rtl/aes_128_key_feeder.sv | 170 +++++++++++++++++
 tb/tb_aes_128_key_feeder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_128_key_feeder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes_128_key_feeder_if
// Purpose  : Round-key write port and core-side handshake for the AES-128
//            key feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_128_key_feeder_if #(
  parameter int KW = 128
);
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [KW-1:0] wr_data;
  logic          dir;
  logic          in_en;
  logic          key_ready;
  logic          out_en;
  logic [KW-1:0] key_round;
  logic          keys_valid;
  logic          busy;
  logic          err_pulse;

  // Key loader / core side: drives writes and block strobes
  modport master (
    output wr_en, wr_addr, wr_data, dir, in_en, key_ready, out_en,
    input  key_round, keys_valid, busy, err_pulse
  );

  // Key feeder side
  modport slave (
    input  wr_en, wr_addr, wr_data, dir, in_en, key_ready, out_en,
    output key_round, keys_valid, busy, err_pulse
  );
endinterface
`default_nettype wire

// File: rtl/aes_128_key_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes_128_key_feeder
// Purpose  : Stores the NR+1 expanded round keys and presents them on
//            key_round in encrypt (ascending) or decrypt (descending) order,
//            advancing on each key_ready from the AES core.
// Revision : 1.0 - initial release
// ============================================================================
module aes_128_key_feeder #(
  parameter int KW = 128,
  parameter int NR = 10
) (
  input  wire logic             clk,
  input  wire logic             kill_n,
  aes_128_key_feeder_if.slave   bus
);

  localparam logic [3:0] c_nr   = 4'(NR);
  localparam logic [3:0] c_zero = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_idx;
  logic [3:0]    w_idx_nxt;
  logic          r_dir;
  logic          w_dir_nxt;
  logic [KW-1:0] r_key_round;
  logic [KW-1:0] w_key_nxt;
  logic          r_err;
  logic          w_err;
  logic          w_wr_ok;
  logic [3:0]    w_first;
  logic [3:0]    w_last;
  logic [3:0]    w_idx_step;

  logic [KW-1:0] r_key [0:NR];
  logic [NR:0]   r_valid_mask;
  logic [NR:0]   w_mask_nxt;
  logic          r_keys_valid;

  // Mask after a legal write; keys_valid is registered from it so it rises on
  // the same edge that stores the final key.
  assign w_mask_nxt = r_valid_mask | ((NR+1)'(1) << bus.wr_addr);

  // Key storage, valid tracking and the all-keys-loaded flag
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      for (int i = 0; i <= NR; i++) begin
        r_key[i] <= '0;
      end
      r_valid_mask <= '0;
      r_keys_valid <= 1'b0;
    end else if (w_wr_ok) begin
      r_key[bus.wr_addr] <= bus.wr_data;
      r_valid_mask       <= w_mask_nxt;
      r_keys_valid       <= &w_mask_nxt;
    end
  end

  // Sequencer state, index, latched direction, key output and error pulse
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_dir       <= 1'b0;
      r_key_round <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_dir       <= w_dir_nxt;
      r_key_round <= w_key_nxt;
      r_err       <= w_err;
    end
  end

  // Next-state, next key and protocol checking
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_dir_nxt   = r_dir;
    w_key_nxt   = r_key_round;
    w_err       = 1'b0;
    w_wr_ok     = 1'b0;
    // first() follows the live dir input; last()/step use the latched one
    w_first     = bus.dir ? c_nr : c_zero;
    w_last      = r_dir ? c_zero : c_nr;
    w_idx_step  = r_dir ? (r_idx - 4'd1) : (r_idx + 4'd1);

    case (r_state)
      ST_IDLE: begin
        if (bus.wr_en) begin
          if (bus.wr_addr <= c_nr) begin
            w_wr_ok = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        if (bus.key_ready) begin
          w_err = 1'b1;
        end
        // Keep the first key preloaded; forward a same-cycle write to it
        w_idx_nxt = w_first;
        if (w_wr_ok && (bus.wr_addr == w_first)) begin
          w_key_nxt = bus.wr_data;
        end else begin
          w_key_nxt = r_key[w_first];
        end
        // Start only if the key set was already complete before this cycle
        if (bus.in_en) begin
          if (r_keys_valid) begin
            w_state_nxt = ST_ACTIVE;
            w_dir_nxt   = bus.dir;
          end else begin
            w_err = 1'b1;
          end
        end
      end

      ST_ACTIVE: begin
        if (bus.wr_en || bus.in_en) begin
          w_err = 1'b1;
        end
        if (bus.key_ready) begin
          w_idx_nxt = w_idx_step;
          w_key_nxt = r_key[w_idx_step];
          if (w_idx_step == w_last) begin
            w_state_nxt = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (bus.wr_en || bus.key_ready) begin
          w_err = 1'b1;
        end
        if (bus.out_en) begin
          w_idx_nxt = w_first;
          w_key_nxt = r_key[w_first];
          if (bus.in_en && r_keys_valid) begin
            w_state_nxt = ST_ACTIVE;
            w_dir_nxt   = bus.dir;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (bus.in_en) begin
          w_err = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.key_round  = r_key_round;
  assign bus.keys_valid = r_keys_valid;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.err_pulse  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_128_key_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aes_128_key_feeder
// Purpose  : Directed and randomized bench for aes_128_key_feeder, compared
//            cycle by cycle against a behavioural key-sequence model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_128_key_feeder;

  localparam int KW = 128;
  localparam int NR = 10;

  logic clk = 1'b0;
  logic kill_n;
  int   n_checks = 0;
  int   n_errors = 0;
  string phase = "init";

  aes_128_key_feeder_if #(.KW(KW)) bus ();

  aes_128_key_feeder #(.KW(KW), .NR(NR)) u_dut (
    .clk    (clk),
    .kill_n (kill_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: key array, loaded flags, and position in the block
  logic [KW-1:0] m_key [0:NR];
  logic [NR:0]   m_vld;
  int            m_cur;
  int            m_left;
  bit            m_busy;
  bit            m_ldir;
  bit            m_err;

  task automatic model_reset();
    for (int i = 0; i <= NR; i++) m_key[i] = '0;
    m_vld = '0; m_cur = 0; m_left = 0; m_busy = 0; m_ldir = 0; m_err = 0;
  endtask

  task automatic model_start();
    m_busy = 1; m_ldir = bus.dir; m_left = NR; m_cur = bus.dir ? NR : 0;
  endtask

  // Apply one clock's worth of inputs to the model
  task automatic model_step();
    bit kv_old;
    int first_i;
    kv_old  = &m_vld;
    first_i = bus.dir ? NR : 0;
    m_err   = 0;
    if (!m_busy) begin
      if (bus.wr_en) begin
        if (int'(bus.wr_addr) <= NR) begin
          m_key[bus.wr_addr] = bus.wr_data;
          m_vld[bus.wr_addr] = 1'b1;
        end else m_err = 1;
      end
      if (bus.key_ready) m_err = 1;
      if (bus.in_en && kv_old) model_start();
      else begin
        if (bus.in_en) m_err = 1;
        m_cur = first_i;
      end
    end else if (m_left > 0) begin
      if (bus.wr_en || bus.in_en) m_err = 1;
      if (bus.key_ready) begin
        m_cur  = m_ldir ? m_cur - 1 : m_cur + 1;
        m_left = m_left - 1;
      end
    end else begin
      if (bus.wr_en || bus.key_ready) m_err = 1;
      if (bus.out_en && bus.in_en) model_start();
      else if (bus.out_en) begin
        m_busy = 0;
        m_cur  = first_i;
      end else if (bus.in_en) m_err = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("key_round",  bus.key_round, m_key[m_cur]);
    chk("keys_valid", KW'(bus.keys_valid), KW'(&m_vld));
    chk("busy",       KW'(bus.busy), KW'(m_busy));
    chk("err_pulse",  KW'(bus.err_pulse), KW'(m_err));
  endtask

  // One clock: model consumes the current inputs, DUT samples them, then
  // outputs are compared 1 ns after the edge and pulse inputs are dropped.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    bus.wr_en = 0; bus.in_en = 0; bus.key_ready = 0; bus.out_en = 0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input int a, input logic [KW-1:0] d);
    bus.wr_en = 1; bus.wr_addr = 4'(a); bus.wr_data = d;
    cyc();
  endtask

  task automatic kr();
    bus.key_ready = 1;
    cyc();
  endtask

  function automatic logic [KW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Asynchronous reset asserted away from the clock edge
  task automatic async_reset();
    kill_n = 0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    kill_n = 1;
  endtask

  // Stimulus sequence
  initial begin
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.dir = 0;
    bus.in_en = 0; bus.key_ready = 0; bus.out_en = 0;
    kill_n = 1;
    model_reset();
    #2 kill_n = 0;
    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    check_outputs();
    kill_n = 1;

    // Load and encrypt
    phase = "load";
    for (int i = 0; i <= NR; i++) wr(i, {16{8'(i)}});
    tick(2);
    phase = "enc";
    bus.dir = 0;
    tick(1);
    bus.in_en = 1;
    cyc();
    chk("enc_first", bus.key_round, '0);
    for (int k = 0; k < NR; k++) begin
      kr();
      tick(2);
    end
    chk("enc_last", bus.key_round, {16{8'h0A}});
    bus.out_en = 1;
    cyc();
    tick(2);

    // Decrypt order
    phase = "dec";
    bus.dir = 1;
    tick(1);
    chk("dec_preload", bus.key_round, {16{8'h0A}});
    bus.in_en = 1;
    cyc();
    for (int k = 0; k < NR; k++) begin
      kr();
      tick(2);
    end
    chk("dec_last", bus.key_round, '0);
    bus.out_en = 1;
    cyc();
    chk("dec_after_out", bus.key_round, {16{8'h0A}});
    tick(2);

    // Protocol errors
    phase = "proto";
    wr(12, rnd128());
    tick(1);
    kr();
    bus.dir = 0;
    tick(1);
    bus.in_en = 1;
    cyc();
    kr();
    wr(3, rnd128());
    tick(1);
    bus.in_en = 1;
    cyc();
    for (int k = 1; k < NR; k++) begin
      kr();
      tick(1);
    end
    kr();
    bus.in_en = 1;
    cyc();
    bus.wr_en = 1; bus.wr_addr = 4'd2; bus.key_ready = 1; bus.in_en = 1;
    cyc();
    tick(1);

    // Back-to-back block with direction flip
    phase = "b2b";
    bus.dir = 1; bus.out_en = 1; bus.in_en = 1;
    cyc();
    chk("b2b_first", bus.key_round, {16{8'h0A}});
    kr();
    chk("b2b_second", bus.key_round, {16{8'h09}});
    for (int k = 1; k < NR; k++) kr();
    bus.out_en = 1;
    cyc();
    tick(2);

    // Randomized traffic against the model
    phase = "rand";
    for (int i = 0; i <= NR; i++) wr(i, rnd128());
    for (int c = 0; c < 500; c++) begin
      bus.wr_en     = ($urandom_range(0, 9) == 0);
      bus.wr_addr   = 4'($urandom_range(0, 15));
      bus.wr_data   = rnd128();
      bus.in_en     = ($urandom_range(0, 7) == 0);
      bus.key_ready = ($urandom_range(0, 2) == 0);
      bus.out_en    = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) bus.dir = ~bus.dir;
      cyc();
    end

    // Async reset mid-block, then incomplete key set
    phase = "arst";
    async_reset();
    for (int i = 0; i <= NR; i++) wr(i, rnd128());
    bus.dir = 0;
    tick(1);
    bus.in_en = 1;
    cyc();
    for (int k = 0; k < 4; k++) kr();
    #2;
    async_reset();
    bus.in_en = 1;
    cyc();
    phase = "partial";
    for (int i = 0; i < NR; i++) wr(i, rnd128());
    bus.in_en = 1;
    cyc();
    tick(1);
    wr(NR, rnd128());
    chk("kv_after_final", KW'(bus.keys_valid), KW'(1));
    tick(1);
    bus.in_en = 1;
    cyc();
    for (int k = 0; k < 3; k++) kr();
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
